reg_bank16_n: RTL and testbench

Sixteen-entry, n-bit register bank that produces the word array consumed by the 16:1 selection mux (`mux16to1_n`). Accepts one write per cycle through a valid/ready port, exposes every entry in parallel on `data_o[0:m-1]`, and supports a sequenced clear that sweeps the bank one entry per cycle. Each entry carries a written-since-clear flag so downstream logic can tell stale zeros from written data.

---
 rtl/reg_bank16_n.sv | 85 ++++++++
 tb/tb_reg_bank16_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank16_n.sv
// Sixteen-entry n-bit register bank with valid/ready write port and a one-entry-per-cycle clear sweep.
// Optional build macro REG_BANK_ZERO_LOCK_EN pins entry 0 to zero and marks it always valid.
module reg_bank16_n #(
    parameter int n       = 4,
    parameter int address = 4,
    parameter int m       = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [address-1:0] wr_addr_i,
    input  logic [n-1:0]       wr_data_i,
    output logic               wr_ready_o,
    input  logic               clr_i,
    output logic               busy_o,
    output logic [n-1:0]       data_o [0:m-1],
    output logic [m-1:0]       valid_o
);

    // state | meaning
    // IDLE  | accepting writes, sampling clr_i
    // CLEAR | sweeping entry cnt to zero, writes stalled
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state;
    logic [address-1:0] cnt;
    logic               busy_q;
    logic [n-1:0]       mem [0:m-1];
    logic [m-1:0]       vld;

    assign wr_ready_o = (state == IDLE) && !clr_i;
    assign busy_o     = busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            vld    <= '0;
            for (int i = 0; i < m; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_i) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else if (we_i && (int'(wr_addr_i) < m)) begin
                        // out-of-range addresses complete the handshake but land nowhere
                        mem[wr_addr_i] <= wr_data_i;
                        vld[wr_addr_i] <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    vld[cnt] <= 1'b0;
                    if (int'(cnt) == m - 1) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < m; i++) data_o[i] = mem[i];
        valid_o = vld;
`ifdef REG_BANK_ZERO_LOCK_EN
        // entry 0 reads as a constant zero that is always considered written
        data_o[0]  = '0;
        valid_o[0] = 1'b1;
`else
`endif
    end

endmodule

// File: tb/tb_reg_bank16_n.sv
// Self-checking bench for reg_bank16_n: directed table, hand-written corner sequences, random traffic vs a model.
module tb_reg_bank16_n;
    localparam int N = 4;
    localparam int A = 4;
    localparam int M = 16;
`ifdef REG_BANK_ZERO_LOCK_EN
    localparam bit ZL = 1'b1;
`else
    localparam bit ZL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           we = 1'b0;
    logic           clr = 1'b0;
    logic [A-1:0]   addr = '0;
    logic [N-1:0]   wdata = '0;
    logic           ready;
    logic           busy;
    logic [N-1:0]   dout [0:M-1];
    logic [M-1:0]   vout;
    logic [3:0]     sel = '0;
    logic [N-1:0]   mux_y;

    reg_bank16_n #(.n(N), .address(A), .m(M)) dut (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wr_addr_i(addr), .wr_data_i(wdata),
        .wr_ready_o(ready), .clr_i(clr), .busy_o(busy), .data_o(dout), .valid_o(vout)
    );

    // behavioural stand-in for the downstream 16:1 selection mux
    assign mux_y = dout[sel];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: entry contents, written flags, and how many sweep edges remain
    int mm [M];
    bit mv [M];
    int sweep_left;

    typedef struct {
        bit       we;
        int       addr;
        int       data;
        bit       clr;
        bit       exp_ready;
        int       exp_entry;
        bit       exp_vbit;
    } vec_t;
    vec_t tbl [16];

    function automatic int exp_data(int i);
        return (ZL && i == 0) ? 0 : mm[i];
    endfunction

    function automatic bit exp_valid(int i);
        return (ZL && i == 0) ? 1'b1 : mv[i];
    endfunction

    function automatic logic [M-1:0] exp_vvec();
        logic [M-1:0] v;
        for (int i = 0; i < M; i++) v[i] = exp_valid(i);
        return v;
    endfunction

    function automatic logic [N*M-1:0] exp_flat();
        logic [N*M-1:0] f;
        for (int i = 0; i < M; i++) f[i*N +: N] = N'(exp_data(i));
        return f;
    endfunction

    function automatic logic [N*M-1:0] dut_flat();
        logic [N*M-1:0] f;
        for (int i = 0; i < M; i++) f[i*N +: N] = dout[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < M; i++) begin
            mm[i] = 0;
            mv[i] = 1'b0;
        end
        sweep_left = 0;
    endtask

    task automatic model_edge(input bit w, input int a, input int d, input bit c);
        if (sweep_left > 0) begin
            mm[M - sweep_left] = 0;
            mv[M - sweep_left] = 1'b0;
            sweep_left--;
        end else if (c) begin
            sweep_left = M;
        end else if (w && a < M) begin
            mm[a] = d;
            mv[a] = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " data"}, 64'(dut_flat()), 64'(exp_flat()));
        chk({tag, " valid"}, 64'(vout), 64'(exp_vvec()));
        chk({tag, " busy"}, 64'(busy), 64'(sweep_left > 0));
    endtask

    // drive one cycle: inputs set, combinational ready checked, edge, model advanced, outputs checked
    task automatic step(input bit w, input int a, input int d, input bit c, input string tag);
        we = w; addr = A'(a); wdata = N'(d); clr = c;
        #1;
        chk({tag, " ready"}, 64'(ready), 64'((sweep_left == 0) && !c));
        @(posedge clk);
        model_edge(w, a, d, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [M-1:0] allv;
        allv = '1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            tbl[i].we        = 1'b1;
            tbl[i].addr      = i;
            tbl[i].data      = i ^ 15;
            tbl[i].clr       = 1'b0;
            tbl[i].exp_ready = 1'b1;
            tbl[i].exp_entry = (ZL && i == 0) ? 0 : (i ^ 15);
            tbl[i].exp_vbit  = 1'b1;
        end

        #1;
        check_all("reset_async");
        #11;
        rst_n = 1'b1;
        #1;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset valid", 64'(vout), 64'(ZL ? 16'h0001 : 16'h0000));
        chk("reset data", 64'(dut_flat()), 64'd0);
        @(posedge clk);
        #1;

        // back-to-back write sweep from the table
        for (int i = 0; i < 16; i++) begin
            we = tbl[i].we; addr = A'(tbl[i].addr); wdata = N'(tbl[i].data); clr = tbl[i].clr;
            #1;
            chk("tbl ready", 64'(ready), 64'(tbl[i].exp_ready));
            @(posedge clk);
            model_edge(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].clr);
            #1;
            chk("tbl entry", 64'(dout[tbl[i].addr]), 64'(tbl[i].exp_entry));
            chk("tbl vbit", 64'(vout[tbl[i].addr]), 64'(tbl[i].exp_vbit));
            check_all("tbl");
        end
        we = 1'b0;
        chk("entry5", 64'(dout[5]), 64'hA);
        chk("valid full", 64'(vout), 64'(allv));
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            #1;
            chk("mux sel", 64'(mux_y), 64'((ZL && s == 0) ? 0 : (s ^ 15)));
        end

        // clear pulse from a full bank
        step(1'b0, 0, 0, 1'b1, "clr_start");
        chk("clr busy high", 64'(busy), 64'd1);
        for (int e = 1; e <= 16; e++) begin
            step(1'b0, 0, 0, 1'b0, "sweep");
            if (e == 3) begin
                chk("sweep e0", 64'(dout[0]), 64'd0);
                chk("sweep e1", 64'(dout[1]), 64'd0);
                chk("sweep e2", 64'(dout[2]), 64'd0);
                chk("sweep e3", 64'(dout[3]), 64'hC);
            end
        end
        chk("clr done data", 64'(dut_flat()), 64'd0);
        chk("clr done valid", 64'(vout), 64'(ZL ? 16'h0001 : 16'h0000));
        chk("clr done busy", 64'(busy), 64'd0);

        // clear collides with a write to entry 7
        step(1'b1, 7, 5, 1'b0, "pre_coll");
        step(1'b1, 7, 3, 1'b1, "coll");
        chk("coll busy", 64'(busy), 64'd1);
        for (int e = 0; e < 16; e++) step(1'b1, 7, 3, 1'b0, "coll_sweep");
        chk("coll entry7", 64'(dout[7]), 64'd0);
        chk("coll valid7", 64'(vout[7]), 64'd0);

        // later of two writes to the same address wins
        step(1'b1, 9, 4, 1'b0, "same1");
        step(1'b1, 9, 6, 1'b0, "same2");
        chk("same addr", 64'(dout[9]), 64'd6);

        // reset in the middle of a sweep
        for (int i = 0; i < 16; i++) step(1'b1, i, (i * 5) & 15, 1'b0, "refill");
        step(1'b0, 0, 0, 1'b1, "mid_clr");
        for (int e = 0; e < 8; e++) step(1'b0, 0, 0, 1'b0, "mid_sweep");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst data", 64'(dut_flat()), 64'd0);
        chk("midrst valid", 64'(vout), 64'(ZL ? 16'h0001 : 16'h0000));
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");

        // write to address 0 (discarded when entry 0 is locked)
        step(1'b1, 0, 9, 1'b0, "addr0");
        chk("addr0 data", 64'(dout[0]), 64'(ZL ? 0 : 9));
        chk("addr0 valid", 64'(vout[0]), 64'd1);

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
